// File: rtl/enc16to4_arb_pkg.sv
// Shared constants and state encoding for the 16-request priority encoder/arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package enc16to4_arb_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    // IDLE: nothing offered (v=0); HOLD: index offered and waiting for ack (v=1).
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // One-hot mask for an index; matches the downstream decoder's select line.
    function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/enc16to4_arb_pri_enc8to3.sv
// Highest-index-wins priority encoder over 8 request bits.
// Latency: purely combinational.
// Backpressure: none; output follows input.
module pri_enc8to3 (
    input  logic [7:0] req,
    output logic [2:0] idx,
    output logic       any
);

    // Scan upward so the last (highest) set bit overrides earlier ones.
    always_comb begin
        idx = 3'd0;
        any = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) begin
                idx = i[2:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enc16to4_arb.sv
// Collects 16 request lines into a pending set and issues one 4-bit index at a time, highest index first.
// Latency: EDGE=1 request edge in cycle n -> pending after edge n+1 -> v/y after edge n+2; one IDLE cycle after each ack.
// Backpressure: v/y held stable until ack, no preemption; e gates capture and new issue but never withdraws an offer.
module enc16to4_arb
    import enc16to4_arb_pkg::*;
#(
    parameter bit EDGE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] w,
    input  logic             e,
    input  logic             ack,
    output logic [IDX_W-1:0] y,
    output logic             v,
    output logic [N_REQ-1:0] pend
);

    logic [N_REQ-1:0] w_d;
    logic [N_REQ-1:0] pend_q;
    logic [N_REQ-1:0] pend_d;
    logic [N_REQ-1:0] cap;
    logic [N_REQ-1:0] clr;
    logic [IDX_W-1:0] y_q;
    logic [IDX_W-1:0] y_d;
    logic [IDX_W-1:0] sel;
    arb_state_t       state_q;
    arb_state_t       state_d;

    logic [2:0] idx_hi;
    logic [2:0] idx_lo;
    logic       any_hi;
    logic       any_lo;
    logic       any;

    // Two 8-bit halves, same split as the decoder's two 3-to-8 stages.
    pri_enc8to3 u_enc_hi (
        .req (pend_q[15:8]),
        .idx (idx_hi),
        .any (any_hi)
    );

    pri_enc8to3 u_enc_lo (
        .req (pend_q[7:0]),
        .idx (idx_lo),
        .any (any_lo)
    );

    assign sel = any_hi ? {1'b1, idx_hi} : {1'b0, idx_lo};
    assign any = any_hi | any_lo;

    // New requests this cycle: rising edges or raw levels, suppressed while disabled.
    always_comb begin
        cap = '0;
        if (e) begin
            cap = EDGE ? (w & ~w_d) : w;
        end
    end

    // Issue/accept control; the accepted index is cleared but a same-cycle capture re-sets it.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (e && any) begin
                    state_d = HOLD;
                    y_d     = sel;
                end
            end
            HOLD: begin
                if (ack) begin
                    state_d = IDLE;
                    clr     = idx_onehot(y_q);
                end
            end
            default: state_d = IDLE;
        endcase
        pend_d = (pend_q & ~clr) | cap;
    end

    // Handshake state and issued index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    // Pending set and previous-w sample; w_d tracks w even while disabled, so edges during e=0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            w_d    <= '0;
        end else begin
            pend_q <= pend_d;
            w_d    <= w;
        end
    end

    assign y    = y_q;
    assign v    = (state_q == HOLD);
    assign pend = pend_q;

endmodule

// File: tb/tb_enc16to4_arb.sv
module tb_enc16to4_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] w;
    logic        e;
    logic        ack1;
    logic        ack0;
    logic [3:0]  y1, y0;
    logic        v1, v0;
    logic [15:0] pend1, pend0;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    enc16to4_arb #(.EDGE(1'b1)) dut_edge (
        .clk(clk), .rst_n(rst_n), .w(w), .e(e), .ack(ack1),
        .y(y1), .v(v1), .pend(pend1)
    );

    enc16to4_arb #(.EDGE(1'b0)) dut_level (
        .clk(clk), .rst_n(rst_n), .w(w), .e(e), .ack(ack0),
        .y(y0), .v(v0), .pend(pend0)
    );

    // Reference model: index 1 = edge-capture instance, index 0 = level-capture instance.
    logic [15:0] m_pend [2];
    logic [3:0]  m_y    [2];
    logic        m_v    [2];
    logic [15:0] m_wd;

    function automatic int highest(input logic [15:0] p);
        return $clog2(int'(p) + 1) - 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_pend[d] = 16'h0;
                m_y[d]    = 4'h0;
                m_v[d]    = 1'b0;
            end
            m_wd = 16'h0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                logic [15:0] newreq;
                logic [15:0] keep;
                logic        a;
                a      = (d == 1) ? ack1 : ack0;
                newreq = !e ? 16'h0 : (d == 1) ? (w & ~m_wd) : w;
                keep   = m_pend[d];
                if (m_v[d]) begin
                    if (a) begin
                        keep[m_y[d]] = 1'b0;
                        m_v[d]       = 1'b0;
                    end
                end else if (e && m_pend[d] != 16'h0) begin
                    m_y[d] = 4'(highest(m_pend[d]));
                    m_v[d] = 1'b1;
                end
                m_pend[d] = keep | newreq;
            end
            m_wd = w;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_v1",    32'(v1),    32'(m_v[1]));
            chk("model_y1",    32'(y1),    32'(m_y[1]));
            chk("model_pend1", 32'(pend1), 32'(m_pend[1]));
            chk("model_v0",    32'(v0),    32'(m_v[0]));
            chk("model_y0",    32'(y0),    32'(m_y[0]));
            chk("model_pend0", 32'(pend0), 32'(m_pend[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        w = 16'h0; e = 1'b0; ack1 = 1'b0; ack0 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Offer in progress on the edge instance: check it, accept it, confirm v drops.
    task automatic accept1(input string name, input logic [3:0] exp_y);
        chk({name, "_v"}, 32'(v1), 32'h1);
        chk({name, "_y"}, 32'(y1), 32'(exp_y));
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        chk({name, "_drop"}, 32'(v1), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        w = 16'h0; e = 1'b0; ack1 = 1'b0; ack0 = 1'b0;
        tick();
        cmp_en = 1'b1;
        do_reset();

        // Quiet inputs: nothing ever issues.
        e = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_v", 32'(v1), 32'h0);
            chk("idle_y", 32'(y1), 32'h0);
            chk("idle_pend", 32'(pend1), 32'h0);
        end

        // Single rising edge on w[5], held high afterwards.
        w = 16'h0020;
        tick();
        chk("s2_pend", 32'(pend1), 32'h0020);
        chk("s2_v_early", 32'(v1), 32'h0);
        tick();
        accept1("s2", 4'd5);
        chk("s2_pend_clr", 32'(pend1), 32'h0);
        for (int i = 0; i < 3; i++) tick();
        chk("s2_no_reissue", 32'(v1), 32'h0);
        w = 16'h0;
        tick();

        // Asynchronous reset while holding an offer.
        w = 16'h0010;
        tick();
        tick();
        chk("ar_hold", 32'(v1), 32'h1);
        #1 rst_n = 1'b0;
        w = 16'h0;
        #1;
        chk("ar_v", 32'(v1), 32'h0);
        chk("ar_y", 32'(y1), 32'h0);
        chk("ar_pend", 32'(pend1), 32'h0);
        rst_n = 1'b1;
        tick();
        e = 1'b1;

        // One-cycle pulse on 15, 8, 0: issued in priority order with an IDLE gap.
        w = 16'h8101;
        tick();
        w = 16'h0;
        chk("s3_pend", 32'(pend1), 32'h8101);
        tick();
        accept1("s3a", 4'd15);
        chk("s3_pend_a", 32'(pend1), 32'h0101);
        tick();
        accept1("s3b", 4'd8);
        tick();
        accept1("s3c", 4'd0);
        chk("s3_pend_end", 32'(pend1), 32'h0);

        // No preemption: w[12] arrives while y=3 is held.
        w = 16'h0008;
        tick();
        tick();
        chk("s4_y3", 32'(y1), 32'd3);
        w = 16'h1008;
        tick();
        w = 16'h0;
        chk("s4_hold_y", 32'(y1), 32'd3);
        chk("s4_hold_v", 32'(v1), 32'h1);
        chk("s4_pend", 32'(pend1), 32'h1008);
        tick();
        accept1("s4a", 4'd3);
        tick();
        accept1("s4b", 4'd12);

        // Same-cycle ack and recapture of the held index.
        w = 16'h0080;
        tick();
        tick();
        w = 16'h0;
        tick();
        chk("s5_y7", 32'(y1), 32'd7);
        w = 16'h0080;
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        chk("s5_drop", 32'(v1), 32'h0);
        chk("s5_keep", 32'(pend1), 32'h0080);
        tick();
        accept1("s5_reissue", 4'd7);
        w = 16'h0;
        tick();

        // Disabled: edge lost, offer still held until ack, then no issue.
        w = 16'h0004;
        tick();
        tick();
        chk("s6_y2", 32'(y1), 32'd2);
        e = 1'b0;
        w = 16'h0204;
        tick();
        w = 16'h0004;
        chk("s6_pend", 32'(pend1), 32'h0004);
        chk("s6_hold", 32'(v1), 32'h1);
        tick();
        accept1("s6_ack", 4'd2);
        tick();
        chk("s6_no_issue", 32'(v1), 32'h0);
        e = 1'b1;
        tick();
        tick();
        chk("s6_lost_v", 32'(v1), 32'h0);
        chk("s6_lost_pend", 32'(pend1), 32'h0);
        w = 16'h0200;
        tick();
        tick();
        accept1("s6_fresh", 4'd9);
        w = 16'h0;
        tick();

        // Level mode: held w[9] is re-issued after every ack.
        do_reset();
        e = 1'b1;
        w = 16'h0200;
        tick();
        chk("lv_pend", 32'(pend0), 32'h0200);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lv_v", 32'(v0), 32'h1);
            chk("lv_y", 32'(y0), 32'd9);
            ack0 = 1'b1;
            tick();
            ack0 = 1'b0;
            chk("lv_drop", 32'(v0), 32'h0);
            chk("lv_keep", 32'(pend0), 32'h0200);
        end
        w = 16'h0;

        // Randomised traffic on both instances, with one asynchronous reset mid-run.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            w    = 16'($urandom) & 16'($urandom) & 16'($urandom);
            e    = ($urandom_range(0, 7) != 0);
            ack1 = 1'($urandom_range(0, 1));
            ack0 = 1'($urandom_range(0, 1));
            if (c == 700) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick();
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
